// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan path: digit-select codes, digit count,
// scan FSM states and small decode helpers.
// Used by the scan controller and by the mux-side logic.
package display_scan_ctrl_pkg;

    localparam logic [1:0] DIG0 = 2'b00;
    localparam logic [1:0] DIG1 = 2'b01;
    localparam logic [1:0] DIG2 = 2'b10;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_SHOW  = 2'b10
    } scan_state_t;

    // Digit order 0 -> 1 -> 2 -> 0; 2'b11 is never produced.
    function automatic logic [1:0] next_digit(input logic [1:0] d);
        logic [1:0] n;
        case (d)
            DIG0:    n = DIG1;
            DIG1:    n = DIG2;
            default: n = DIG0;
        endcase
        return n;
    endfunction

    // Active-low enable with only the selected digit's bit low.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] d);
        logic [NUM_DIGITS-1:0] a;
        case (d)
            DIG0:    a = 3'b110;
            DIG1:    a = 3'b101;
            default: a = 3'b011;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_counter.sv
// Slot counter: counts 0..PRESCALE-1 and wraps; last flags the final count.
// Latency: count updates one cycle after en; last is combinational from count.
// Backpressure: en low freezes the count; clr forces zero and wins over en.
// Ports: clk, reset_n (async, active-low), clr, en, count, last.
module slot_counter #(
    parameter int PRESCALE = 50000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        en,
    output logic [$clog2(PRESCALE)-1:0] count,
    output logic                        last
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST_VAL = CW'(PRESCALE - 1);

    assign last = (count == LAST_VAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Three-digit 7-segment scan controller: digit select, blanked active-low anodes, frame pulse.
// Latency: first slot starts on the edge after enable is seen in IDLE; all outputs registered.
// Backpressure: hold freezes slot position and outputs; enable low returns to IDLE (wins over hold).
// Ports: clk, reset_n (async, active-low), enable, hold -> control[1:0], anode[2:0], frame_done.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       hold,
    output logic [1:0] control,
    output logic [2:0] anode,
    output logic       frame_done
);

    localparam int CW = $clog2(PRESCALE);
    // Unused when BLANK == 0 since the BLANK state is never entered then.
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t   state;
    logic [1:0]    digit;
    logic [CW-1:0] count;
    logic          last;
    logic          running;
    logic          cnt_clr;
    logic          cnt_en;

    assign running = (state != ST_IDLE);
    // Counter sits at zero while idle so each start begins on a fresh slot.
    assign cnt_clr = !enable || !running;
    assign cnt_en  = running && !hold;

    slot_counter #(
        .PRESCALE(PRESCALE)
    ) u_slot_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .count   (count),
        .last    (last)
    );

    // The digit register is the registered mux select.
    assign control = digit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            digit      <= DIG0;
            anode      <= 3'b111;
            frame_done <= 1'b0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            digit      <= DIG0;
            anode      <= 3'b111;
            frame_done <= 1'b0;
        end else begin
            // Pulse by default; only a 2->0 wrap re-asserts it below.
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    digit <= DIG0;
                    if (BLANK == 0) begin
                        state <= ST_SHOW;
                        anode <= anode_for(DIG0);
                    end else begin
                        state <= ST_BLANK;
                        anode <= 3'b111;
                    end
                end
                ST_BLANK: begin
                    if (!hold && count == BLANK_LAST) begin
                        state <= ST_SHOW;
                        anode <= anode_for(digit);
                    end
                end
                ST_SHOW: begin
                    if (!hold && last) begin
                        // Select changes together with the anode going dark, so
                        // the mux settles before the next digit lights.
                        digit      <= next_digit(digit);
                        frame_done <= (digit == DIG2);
                        if (BLANK == 0) begin
                            state <= ST_SHOW;
                            anode <= anode_for(next_digit(digit));
                        end else begin
                            state <= ST_BLANK;
                            anode <= 3'b111;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    digit <= DIG0;
                    anode <= 3'b111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: BLANK=2 and BLANK=0 instances share stimulus and are
// compared each cycle against a frame-position model, plus literal timing checks.
module tb_display_scan_ctrl;

    localparam int P     = 8;
    localparam int FRAME = 3 * P;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] control_a, control_b;
    logic [2:0] anode_a, anode_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Model: a running flag, position within a 3-slot frame, and the wrap pulse.
    bit m_active[2];
    int m_t[2];
    bit m_fd[2];
    bit en_last;
    bit prev_lit_b;
    int blank_of[2] = '{2, 0};

    always #5 clk = ~clk;

    display_scan_ctrl #(.PRESCALE(P), .BLANK(2)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .hold       (hold),
        .control    (control_a),
        .anode      (anode_a),
        .frame_done (fd_a)
    );

    display_scan_ctrl #(.PRESCALE(P), .BLANK(0)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .hold       (hold),
        .control    (control_b),
        .anode      (anode_b),
        .frame_done (fd_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] <= 1'b0;
                m_t[i]      <= 0;
                m_fd[i]     <= 1'b0;
            end
            en_last <= 1'b0;
        end else begin
            en_last <= enable;
            for (int i = 0; i < 2; i++) begin
                if (!enable) begin
                    m_active[i] <= 1'b0;
                    m_t[i]      <= 0;
                    m_fd[i]     <= 1'b0;
                end else if (!m_active[i]) begin
                    m_active[i] <= 1'b1;
                    m_t[i]      <= 0;
                    m_fd[i]     <= 1'b0;
                end else if (hold) begin
                    m_fd[i] <= 1'b0;
                end else begin
                    m_t[i]  <= (m_t[i] + 1) % FRAME;
                    m_fd[i] <= ((m_t[i] + 1) % FRAME) == 0;
                end
            end
        end
    end

    function automatic logic [2:0] exp_anode(input int i);
        logic [2:0] one;
        one = 3'b001;
        if (!m_active[i] || (m_t[i] % P) < blank_of[i]) return 3'b111;
        return ~(one << (m_t[i] / P));
    endfunction

    function automatic int exp_control(input int i);
        return m_active[i] ? (m_t[i] / P) : 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_control_a", control_a, exp_control(0));
            chk("model_anode_a", anode_a, exp_anode(0));
            chk("model_frame_done_a", fd_a, m_fd[0]);
            chk("model_control_b", control_b, exp_control(1));
            chk("model_anode_b", anode_b, exp_anode(1));
            chk("model_frame_done_b", fd_b, m_fd[1]);
            chk("inv_control_not_11_a", control_a != 2'b11, 1);
            chk("inv_control_not_11_b", control_b != 2'b11, 1);
            chk("inv_one_anode_a", $countones(~anode_a) <= 1, 1);
            chk("inv_one_anode_b", $countones(~anode_b) <= 1, 1);
            if (prev_lit_b && en_last)
                chk("inv_blank0_no_dark_gap", anode_b != 3'b111, 1);
            prev_lit_b <= (anode_b != 3'b111);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int lit;
        #1 reset_n = 1'b0;
        enable = 1'b1;
        hold   = 1'b0;
        @(negedge clk);
        chk("reset_control", control_a, 0);
        chk("reset_anode", anode_a, 3'b111);
        chk("reset_frame_done", fd_a, 0);
        cmp_on  = 1'b1;
        reset_n = 1'b1;

        // Slot timing from the first start: 2 dark, 6 lit per digit.
        tick(1);
        chk("start_control", control_a, 0);
        chk("start_anode_dark", anode_a, 3'b111);
        chk("start_b_lit", anode_b, 3'b110);
        tick(1);
        chk("blank2_anode", anode_a, 3'b111);
        tick(1);
        chk("dig0_lit", anode_a, 3'b110);
        tick(5);
        chk("dig0_last_lit", anode_a, 3'b110);
        tick(1);
        chk("dig1_control", control_a, 1);
        chk("dig1_dark", anode_a, 3'b111);
        tick(2);
        chk("dig1_lit", anode_a, 3'b101);
        tick(6);
        chk("dig2_control", control_a, 2);
        chk("dig2_dark", anode_a, 3'b111);
        tick(2);
        chk("dig2_lit", anode_a, 3'b011);
        tick(5);
        chk("pre_wrap_no_frame_done", fd_a, 0);
        tick(1);
        chk("wrap_frame_done", fd_a, 1);
        chk("wrap_control", control_a, 0);
        chk("wrap_anode", anode_a, 3'b111);
        tick(1);
        chk("frame_done_drops", fd_a, 0);

        // Hold mid-SHOW of digit 1: lit period stretches to 6 + 5 cycles.
        tick(9);
        chk("hold_pre_lit", anode_a, 3'b101);
        lit = 1;
        tick(1);
        if (anode_a == 3'b101) lit++;
        hold = 1'b1;
        repeat (5) begin
            tick(1);
            if (anode_a == 3'b101) lit++;
        end
        chk("hold_frozen_control", control_a, 1);
        hold = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (anode_a == 3'b101) lit++;
            else break;
        end
        chk("hold_slot_lit_cycles", lit, 11);
        chk("after_hold_control", control_a, 2);

        // Enable dropped mid-SHOW of digit 2 while held.
        tick(3);
        chk("dig2_lit_before_drop", anode_a, 3'b011);
        hold   = 1'b1;
        enable = 1'b0;
        tick(1);
        chk("drop_control", control_a, 0);
        chk("drop_anode", anode_a, 3'b111);
        chk("drop_frame_done", fd_a, 0);
        enable = 1'b1;
        hold   = 1'b0;
        tick(1);
        chk("restart_control", control_a, 0);
        chk("restart_anode", anode_a, 3'b111);
        tick(2);
        chk("restart_dig0_lit", anode_a, 3'b110);

        // Asynchronous reset between edges during SHOW.
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_anode", anode_a, 3'b111);
        chk("async_reset_control", control_a, 0);
        chk("async_reset_anode_b", anode_b, 3'b111);
        #1 reset_n = 1'b1;
        tick(1);

        // Random enable/hold soak with per-cycle model comparison.
        for (int n = 0; n < 1000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            hold   = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
